core_bus_arbiter: RTL and testbench
===================================

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_FIRST, default 1, meaning that when 1, dreq wins a same-cycle tie with ireq, and when 0, ties alternate round-robin.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 Port ireq, input, ibus_req_t: instruction request from the core (valid, addr).
REQ-006 Port iresp, output, ibus_resp_t: instruction response (addr_ok, data_ok, data).
REQ-007 Port dreq, input, dbus_req_t: data request from the core (valid, addr, size, strobe, data).
REQ-008 Port dresp, output, dbus_resp_t: data response (addr_ok, data_ok, data).
REQ-009 Port creq, output, cbus_req_t: single-beat memory request (valid, is_write, size, addr, strobe, data).
REQ-010 Port cresp, input, cbus_resp_t: memory response (ready, last, data).
REQ-011 Ports perf_icnt, perf_dcnt and perf_wait, outputs, CNT_W each: counts of granted I transactions, granted D transactions, and cycles spent waiting on memory.

Function
REQ-012 The arbiter SHALL implement the FSM states IDLE, WAIT_I, WAIT_D, RESP_I and RESP_D.
REQ-013 In IDLE, a valid request SHALL be accepted in the same cycle: addr_ok=1 to the winner only, the request is latched into the hold register, and the FSM moves to WAIT_I or WAIT_D.
REQ-014 On a tie in IDLE: if DATA_FIRST=1, D SHALL win; if DATA_FIRST=0, the grant SHALL go to the port that did not win last, with I winning the first tie after reset.
REQ-015 The losing requester SHALL see addr_ok=0 and SHALL be served on a later IDLE cycle, with no request dropped.
REQ-016 In WAIT_x, creq SHALL be driven from the hold register with valid=1, independent of the live ireq/dreq inputs.
REQ-017 creq.is_write SHALL be 1 exactly when the held D request has a nonzero strobe; an I request SHALL always have is_write=0, strobe=0 and size=word.
REQ-018 In WAIT_x, cresp.ready&&cresp.last SHALL capture cresp.data and move the FSM to RESP_x.
REQ-019 RESP_x SHALL assert data_ok=1 with the captured data to the owner for exactly one cycle, then return to IDLE.
REQ-020 No new request SHALL be accepted in RESP_x; minimum latency is accept at cycle N, creq.valid at N+1, and data_ok at N+2 when memory answers at N+1.
REQ-021 A cresp.ready without last SHALL be ignored, as the bus is single-beat.
REQ-022 cresp SHALL be ignored in IDLE and RESP_x.
REQ-023 All response fields of the non-owner SHALL be 0 every cycle.
REQ-024 The grant SHALL never change while in WAIT_x or RESP_x.

Reset
REQ-025 resetn=0 SHALL asynchronously force FSM=IDLE, hold register='0, last-winner=D, and all counters=0.
REQ-026 While resetn=0, iresp, dresp and creq SHALL all be '0.
REQ-027 Reset asserted in WAIT_x SHALL abandon the transaction with no data_ok afterward.
REQ-028 After resetn rises, the first acceptance SHALL be possible in the first clock edge cycle.

Configuration
REQ-029 With CORE_BUS_ARB_PERF_EN defined, perf_icnt SHALL increment on each I acceptance, perf_dcnt on each D acceptance, and perf_wait on each WAIT_x cycle.
REQ-030 All three counters SHALL wrap modulo 2^CNT_W.
REQ-031 Without CORE_BUS_ARB_PERF_EN, the counters SHALL not be instantiated and perf_* SHALL be tied to '0.

Structure
REQ-032 The typedefs ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, cbus_req_t, cbus_resp_t and the FSM state enum SHALL live in the shared CPU defs package.
REQ-033 Arbitration SHALL be implemented in the single sub-module bus_arb_pick, a registered-last-winner priority picker.

Verification
REQ-034 Single I fetch: ireq.valid, addr=0xBFC00000; memory ready+last at N+1 with data 0x24020001 -> iresp.addr_ok at N, data_ok with 0x24020001 at N+2, and perf_icnt=1.
REQ-035 Tie with DATA_FIRST=1: ireq and dreq valid together -> D granted first, I granted in the first IDLE after RESP_D.
REQ-036 Tie with DATA_FIRST=0, two consecutive ties -> grants I, D, I, D.
REQ-037 D store: strobe=4'b0011, data=0x12345678, memory delays 5 cycles -> creq.is_write=1 held stable for all 5 cycles, perf_wait=5, and exactly one data_ok.
REQ-038 Reset in WAIT_D -> outputs '0 immediately, no data_ok after release, and the next ireq is served normally.
REQ-039 Counter wrap with CNT_W=4: 17 I fetches -> perf_icnt=1; with the macro undefined, perf_*=0 throughout.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// Shared CPU bus definitions for core_bus_arbiter: request/response structs for the
// instruction, data and memory (cbus) ports, plus the arbiter FSM state encoding.
package core_bus_arbiter_pkg;

    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Two-way priority picker with a registered last-winner flag. Ties go to D when
// DATA_FIRST is nonzero, otherwise to whichever port did not win the previous grant.
module bus_arb_pick #(
    parameter int unsigned DATA_FIRST = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic gnt_i,
    output logic gnt_d
);

    logic last_d_q;

    // Grant selection; last_d_q only matters on a tie in round-robin mode
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            gnt_d = (DATA_FIRST != 0) ? 1'b1 : ~last_d_q;
            gnt_i = ~gnt_d;
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end

    // Remember the most recent winner; reset to D so the first tie goes to I
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_d_q <= 1'b1;
        end else if (take) begin
            last_d_q <= gnt_d;
        end else begin
            last_d_q <= last_d_q;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Arbitrates the core's instruction and data buses onto one single-beat memory bus.
// Define CORE_BUS_ARB_PERF_EN to build the perf_icnt/perf_dcnt/perf_wait counters.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_FIRST = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  ibus_req_t        ireq,
    output ibus_resp_t       iresp,
    input  dbus_req_t        dreq,
    output dbus_resp_t       dresp,
    output cbus_req_t        creq,
    input  cbus_resp_t       cresp,
    output logic [CNT_W-1:0] perf_icnt,
    output logic [CNT_W-1:0] perf_dcnt,
    output logic [CNT_W-1:0] perf_wait
);

    arb_state_t  state_q;
    cbus_req_t   hold_q;
    logic [31:0] rdata_q;
    logic        idle_s;
    logic        gnt_i_s;
    logic        gnt_d_s;
    logic        beat_done_s;

    assign idle_s      = resetn && (state_q == IDLE);
    assign beat_done_s = cresp.ready && cresp.last;

    bus_arb_pick #(
        .DATA_FIRST(DATA_FIRST)
    ) u_pick (
        .clk   (clk),
        .resetn(resetn),
        .req_i (idle_s && ireq.valid),
        .req_d (idle_s && dreq.valid),
        .take  (idle_s && (ireq.valid || dreq.valid)),
        .gnt_i (gnt_i_s),
        .gnt_d (gnt_d_s)
    );

    // Arbiter FSM: accept in IDLE, hold the request until the memory beat, answer once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d_s) begin
                        hold_q.valid    <= 1'b0;
                        hold_q.is_write <= |dreq.strobe;
                        hold_q.size     <= dreq.size;
                        hold_q.addr     <= dreq.addr;
                        hold_q.strobe   <= dreq.strobe;
                        hold_q.data     <= dreq.data;
                        state_q         <= WAIT_D;
                    end else if (gnt_i_s) begin
                        hold_q.valid    <= 1'b0;
                        hold_q.is_write <= 1'b0;
                        hold_q.size     <= SIZE_WORD;
                        hold_q.addr     <= ireq.addr;
                        hold_q.strobe   <= 4'b0000;
                        hold_q.data     <= 32'h0000_0000;
                        state_q         <= WAIT_I;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (beat_done_s) begin
                        rdata_q <= cresp.data;
                        state_q <= (state_q == WAIT_I) ? RESP_I : RESP_D;
                    end else begin
                        state_q <= state_q;
                    end
                end
                RESP_I, RESP_D: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

    // Output decode: acceptance is same-cycle, everything else follows the registered state
    always_comb begin
        iresp         = '0;
        dresp         = '0;
        creq          = '0;
        iresp.addr_ok = gnt_i_s;
        dresp.addr_ok = gnt_d_s;
        case (state_q)
            WAIT_I, WAIT_D: begin
                creq       = hold_q;
                creq.valid = 1'b1;
            end
            RESP_I: begin
                iresp.data_ok = 1'b1;
                iresp.data    = rdata_q;
            end
            RESP_D: begin
                dresp.data_ok = 1'b1;
                dresp.data    = rdata_q;
            end
            default: creq = '0;
        endcase
    end

`ifdef CORE_BUS_ARB_PERF_EN
    logic [CNT_W-1:0] icnt_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             waiting_s;

    assign waiting_s = (state_q == WAIT_I) || (state_q == WAIT_D);

    // Free-running performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            icnt_q <= '0;
            dcnt_q <= '0;
            wcnt_q <= '0;
        end else begin
            icnt_q <= icnt_q + CNT_W'(gnt_i_s);
            dcnt_q <= dcnt_q + CNT_W'(gnt_d_s);
            wcnt_q <= wcnt_q + CNT_W'(waiting_s);
        end
    end

    assign perf_icnt = icnt_q;
    assign perf_dcnt = dcnt_q;
    assign perf_wait = wcnt_q;
`else
    assign perf_icnt = '0;
    assign perf_dcnt = '0;
    assign perf_wait = '0;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: one default instance and one round-robin,
// 4-bit-counter instance share stimulus; expected counters follow CORE_BUS_ARB_PERF_EN.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

`ifdef CORE_BUS_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    ibus_req_t  ireq;
    dbus_req_t  dreq;
    cbus_resp_t cresp;
    ibus_resp_t iresp_a, iresp_b;
    dbus_resp_t dresp_a, dresp_b;
    cbus_req_t  creq_a, creq_b;
    logic [31:0] icnt_a, dcnt_a, wait_a;
    logic [3:0]  icnt_b, dcnt_b, wait_b;
    int errors_n = 0;
    int checks_n = 0;

    always #5 clk = ~clk;

    core_bus_arbiter u_dut (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp_a), .dreq(dreq), .dresp(dresp_a),
        .creq(creq_a), .cresp(cresp), .perf_icnt(icnt_a), .perf_dcnt(dcnt_a), .perf_wait(wait_a)
    );

    core_bus_arbiter #(.DATA_FIRST(0), .CNT_W(4)) u_dut_rr (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp_b), .dreq(dreq), .dresp(dresp_b),
        .creq(creq_b), .cresp(cresp), .perf_icnt(icnt_b), .perf_dcnt(dcnt_b), .perf_wait(wait_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pe(input int unsigned v);
        return PERF_ON ? 64'(v) : 64'd0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        resetn = 1'b0;
        ireq   = '0;
        dreq   = '0;
        cresp  = '0;
        next_cycle();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with live requests and a memory beat present: everything must read zero
        resetn = 1'b0;
        ireq   = '{valid: 1'b1, addr: 32'hBFC0_0000};
        dreq   = '{valid: 1'b1, addr: 32'h0000_0004, size: 2'd2, strobe: 4'hF, data: 32'h1};
        cresp  = '{ready: 1'b1, last: 1'b1, data: 32'hFFFF};
        #12;
        chk("rst_iresp", 64'(iresp_a), 64'd0);
        chk("rst_dresp", 64'(dresp_a), 64'd0);
        chk("rst_creq", 64'(|creq_a), 64'd0);
        chk("rst_icnt", 64'(icnt_a), 64'd0);
        ireq  = '0;
        dreq  = '0;
        cresp = '0;
        next_cycle();
        resetn = 1'b1;

        // Single I fetch, accepted in the first cycle after reset release
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
        sample();
        chk("i1_aok", 64'(iresp_a.addr_ok), 64'd1);
        chk("i1_d_aok", 64'(dresp_a.addr_ok), 64'd0);
        next_cycle();
        ireq  = '0;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'h2402_0001};
        sample();
        chk("i1_cvalid", 64'(creq_a.valid), 64'd1);
        chk("i1_caddr", 64'(creq_a.addr), 64'hBFC0_0000);
        chk("i1_cwr", 64'(creq_a.is_write), 64'd0);
        chk("i1_cstrb", 64'(creq_a.strobe), 64'd0);
        chk("i1_csize", 64'(creq_a.size), 64'd2);
        chk("i1_dok_early", 64'(iresp_a.data_ok), 64'd0);
        next_cycle();
        cresp = '0;
        sample();
        chk("i1_dok", 64'(iresp_a.data_ok), 64'd1);
        chk("i1_data", 64'(iresp_a.data), 64'h2402_0001);
        chk("i1_icnt", 64'(icnt_a), pe(1));
        next_cycle();
        sample();
        chk("i1_dok_once", 64'(iresp_a.data_ok), 64'd0);

        // Tie with DATA_FIRST=1: D first, then I in the first IDLE after RESP_D
        next_cycle();
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0004};
        dreq = '{valid: 1'b1, addr: 32'h8000_0010, size: 2'd2, strobe: 4'h0, data: 32'h0};
        sample();
        chk("tie_d_aok", 64'(dresp_a.addr_ok), 64'd1);
        chk("tie_i_aok", 64'(iresp_a.addr_ok), 64'd0);
        next_cycle();
        dreq.valid = 1'b0;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'hD0D0_D0D0};
        sample();
        chk("tie_caddr_d", 64'(creq_a.addr), 64'h8000_0010);
        chk("tie_cwr_d", 64'(creq_a.is_write), 64'd0);
        chk("tie_i_wait", 64'(iresp_a.addr_ok), 64'd0);
        next_cycle();
        cresp = '0;
        sample();
        chk("tie_d_dok", 64'(dresp_a.data_ok), 64'd1);
        chk("tie_d_data", 64'(dresp_a.data), 64'hD0D0_D0D0);
        chk("tie_i_zero", 64'(iresp_a), 64'd0);
        next_cycle();
        sample();
        chk("tie_i_aok2", 64'(iresp_a.addr_ok), 64'd1);
        next_cycle();
        ireq.valid = 1'b0;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'h1111_2222};
        sample();
        chk("tie_caddr_i", 64'(creq_a.addr), 64'hBFC0_0004);
        next_cycle();
        cresp = '0;
        sample();
        chk("tie_i_data", 64'(iresp_a.data), 64'h1111_2222);
        chk("tie_d_zero", 64'(dresp_a), 64'd0);

        // D store with a 5-cycle memory delay and a stray ready-without-last
        next_cycle();
        dreq = '{valid: 1'b1, addr: 32'h8000_1000, size: 2'd1, strobe: 4'b0011, data: 32'h1234_5678};
        sample();
        chk("st_aok", 64'(dresp_a.addr_ok), 64'd1);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            dreq = '{valid: 1'b1, addr: 32'hDEAD_0000 + 32'(c), size: 2'd2, strobe: 4'h0, data: 32'h0};
            if (c == 4) cresp = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_F00D};
            else if (c == 1) cresp = '{ready: 1'b1, last: 1'b0, data: 32'h0BAD_0BAD};
            else cresp = '0;
            sample();
            chk($sformatf("st_cvalid%0d", c), 64'(creq_a.valid), 64'd1);
            chk($sformatf("st_cwr%0d", c), 64'(creq_a.is_write), 64'd1);
            chk($sformatf("st_caddr%0d", c), 64'(creq_a.addr), 64'h8000_1000);
            chk($sformatf("st_cdata%0d", c), 64'(creq_a.data), 64'h1234_5678);
            chk($sformatf("st_cstrb%0d", c), 64'(creq_a.strobe), 64'h3);
            chk($sformatf("st_csize%0d", c), 64'(creq_a.size), 64'd1);
            chk($sformatf("st_dresp%0d", c), 64'(dresp_a), 64'd0);
        end
        next_cycle();
        dreq  = '0;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'h0BAD_BAD0};
        sample();
        chk("st_dok", 64'(dresp_a.data_ok), 64'd1);
        chk("st_data", 64'(dresp_a.data), 64'hCAFE_F00D);
        next_cycle();
        sample();
        chk("st_dok_once", 64'(dresp_a.data_ok), 64'd0);
        chk("st_idle_creq", 64'(creq_a.valid), 64'd0);
        chk("st_icnt", 64'(icnt_a), pe(2));
        chk("st_dcnt", 64'(dcnt_a), pe(2));
        chk("st_wait", 64'(wait_a), pe(8));
        next_cycle();
        cresp = '0;
        sample();
        chk("idle_ign_creq", 64'(creq_a.valid), 64'd0);
        chk("idle_ign_dresp", 64'(dresp_a), 64'd0);

        // Reset while in WAIT_D: transaction abandoned, next I fetch served normally
        next_cycle();
        dreq = '{valid: 1'b1, addr: 32'h8000_2000, size: 2'd2, strobe: 4'h0, data: 32'h0};
        sample();
        chk("rw_aok", 64'(dresp_a.addr_ok), 64'd1);
        next_cycle();
        dreq = '0;
        sample();
        chk("rw_cvalid", 64'(creq_a.valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rw_creq0", 64'(|creq_a), 64'd0);
        chk("rw_dresp0", 64'(dresp_a), 64'd0);
        chk("rw_iresp0", 64'(iresp_a), 64'd0);
        chk("rw_dcnt0", 64'(dcnt_a), 64'd0);
        next_cycle();
        resetn = 1'b1;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
        ireq  = '{valid: 1'b1, addr: 32'hBFC0_0100};
        sample();
        chk("rw_i_aok", 64'(iresp_a.addr_ok), 64'd1);
        chk("rw_no_dok0", 64'(dresp_a.data_ok), 64'd0);
        next_cycle();
        ireq  = '0;
        cresp = '{ready: 1'b1, last: 1'b1, data: 32'h2402_0002};
        sample();
        chk("rw_caddr", 64'(creq_a.addr), 64'hBFC0_0100);
        chk("rw_no_dok1", 64'(dresp_a.data_ok), 64'd0);
        next_cycle();
        cresp = '0;
        sample();
        chk("rw_i_data", 64'(iresp_a.data), 64'h2402_0002);
        chk("rw_i_dok", 64'(iresp_a.data_ok), 64'd1);
        chk("rw_no_dok2", 64'(dresp_a.data_ok), 64'd0);
        chk("rw_icnt", 64'(icnt_a), pe(1));
        chk("rw_wait", 64'(wait_a), pe(1));

        // Round-robin ties after reset on the DATA_FIRST=0 instance: I, D, I, D
        do_reset();
        ireq = '{valid: 1'b1, addr: 32'hBFC0_2000};
        dreq = '{valid: 1'b1, addr: 32'h8000_3000, size: 2'd2, strobe: 4'h0, data: 32'h0};
        for (int k = 0; k < 4; k++) begin
            sample();
            chk($sformatf("rr_i_aok%0d", k), 64'(iresp_b.addr_ok), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_d_aok%0d", k), 64'(dresp_b.addr_ok), (k % 2 == 1) ? 64'd1 : 64'd0);
            chk($sformatf("df_d_aok%0d", k), 64'(dresp_a.addr_ok), 64'd1);
            next_cycle();
            cresp = '{ready: 1'b1, last: 1'b1, data: 32'h100 + 32'(k)};
            sample();
            chk($sformatf("rr_caddr%0d", k), 64'(creq_b.addr),
                (k % 2 == 0) ? 64'hBFC0_2000 : 64'h8000_3000);
            next_cycle();
            cresp = '0;
            sample();
            chk($sformatf("rr_i_dok%0d", k), 64'(iresp_b.data_ok), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_d_dok%0d", k), 64'(dresp_b.data_ok), (k % 2 == 1) ? 64'd1 : 64'd0);
            next_cycle();
        end
        ireq = '0;
        dreq = '0;
        sample();
        chk("rr_icnt", 64'(icnt_b), pe(2));
        chk("rr_dcnt", 64'(dcnt_b), pe(2));

        // 17 I fetches: the 4-bit counters wrap to 1, the 32-bit ones reach 17
        do_reset();
        for (int k = 0; k < 17; k++) begin
            ireq = '{valid: 1'b1, addr: 32'hBFC0_1000 + 32'(k * 4)};
            sample();
            chk($sformatf("wr_aok%0d", k), 64'(iresp_b.addr_ok), 64'd1);
            next_cycle();
            ireq  = '0;
            cresp = '{ready: 1'b1, last: 1'b1, data: 32'(k)};
            next_cycle();
            cresp = '0;
            sample();
            chk($sformatf("wr_data%0d", k), 64'(iresp_b.data), 64'(k));
            next_cycle();
        end
        sample();
        chk("wr_icnt_b", 64'(icnt_b), pe(1));
        chk("wr_wait_b", 64'(wait_b), pe(1));
        chk("wr_dcnt_b", 64'(dcnt_b), 64'd0);
        chk("wr_icnt_a", 64'(icnt_a), pe(17));
        chk("wr_wait_a", 64'(wait_a), pe(17));

        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end

endmodule
